// File: rtl/dda_spi_pkg.sv
// dda_spi_pkg: opcodes, frame length and FSM encoding shared by the DDA SPI front end
package dda_spi_pkg;
    localparam int FRAME_BITS = 32;
    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_WR_MU   = 8'h01;
    localparam logic [7:0] OP_WR_ICX  = 8'h02;
    localparam logic [7:0] OP_WR_ICY  = 8'h03;
    localparam logic [7:0] OP_LOAD_IC = 8'h04;
    localparam logic [7:0] OP_STEP    = 8'h05;
    localparam logic [7:0] OP_CLR_ERR = 8'h06;
    typedef enum logic [1:0] {IDLE, SHIFT, EXEC, DRAIN} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 3-flop synchronizer for an asynchronous pin with one-cycle rise/fall pulses
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [2:0] sr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr <= '0;
        else sr <= {sr[1:0], din};
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/dda_spi_ctrl.sv
// dda_spi_ctrl: SPI-slave command decoder driving DDA parameters and step/load controls
module dda_spi_ctrl
    import dda_spi_pkg::*;
#(
    parameter int          N      = 16,
    parameter logic [N-1:0] MU_RST = 16'h0000,
    parameter logic [N-1:0] IC_RST = 16'h3000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sclk,
    input  logic         cs_n,
    input  logic         mosi,
    output logic         miso,
    output logic         miso_oe,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] mu,
    output logic [N-1:0] icx,
    output logic [N-1:0] icy,
    output logic         load_ic,
    output logic         step_req,
    input  logic         step_ack,
    output logic         frame_err,
    output logic [7:0]   err_cnt
);
    localparam int CW = $clog2(FRAME_BITS);
    logic sclk_rise, sclk_fall, cs_rise, cs_fall, err, bad_op, extra;
    logic [1:0] mosi_sr;
    logic [FRAME_BITS-1:0] rx;
    logic [2*N-1:0] tx;
    logic [CW-1:0] cnt;
    logic [7:0] op;
    state_t state, state_nx;

    spi_sync_edge u_sclk (.clk(clk), .rst_n(rst_n), .din(sclk), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge u_cs   (.clk(clk), .rst_n(rst_n), .din(cs_n), .rise(cs_rise), .fall(cs_fall));

    assign op     = rx[FRAME_BITS-1 -: 8];
    assign bad_op = op > OP_CLR_ERR || (op == OP_STEP && step_req);
    assign miso   = tx[2*N-1];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        err = 1'b0;
        case (state)
            IDLE:  state_nx = cs_fall ? SHIFT : IDLE;
            SHIFT: begin
                state_nx = cs_rise ? IDLE :
                           (sclk_rise && cnt == CW'(FRAME_BITS - 1)) ? EXEC : SHIFT;
                err = cs_rise;
            end
            EXEC: begin
                state_nx = cs_rise ? IDLE : DRAIN;
                err = bad_op;
            end
            DRAIN: begin
                state_nx = cs_rise ? IDLE : DRAIN;
                err = sclk_rise & ~extra;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sr   <= '0;
            miso_oe   <= 1'b0;
            rx        <= '0;
            tx        <= '0;
            cnt       <= '0;
            extra     <= 1'b0;
            mu        <= MU_RST;
            icx       <= IC_RST;
            icy       <= IC_RST;
            load_ic   <= 1'b0;
            step_req  <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            mosi_sr <= {mosi_sr[0], mosi};
            miso_oe <= cs_fall | (miso_oe & ~cs_rise);
            // snapshot {x,y} exactly at frame start so later core updates cannot tear the readback
            if (state == IDLE && cs_fall) begin
                tx    <= {x, y};
                cnt   <= '0;
                extra <= 1'b0;
            end else if (state != IDLE && sclk_fall) begin
                tx <= {tx[2*N-2:0], 1'b0};
            end
            if (state == SHIFT && sclk_rise) begin
                rx  <= {rx[FRAME_BITS-2:0], mosi_sr[1]};
                cnt <= cnt + 1'b1;
            end
            if (state == DRAIN && sclk_rise) extra <= 1'b1;
            if (state == EXEC)
                case (op)
                    OP_NOP:    ;
                    OP_WR_MU:  mu  <= rx[N-1:0];
                    OP_WR_ICX: icx <= rx[N-1:0];
                    OP_WR_ICY: icy <= rx[N-1:0];
                    default:   ;
                endcase
            load_ic  <= state == EXEC && op == OP_LOAD_IC;
            step_req <= (state == EXEC && op == OP_STEP && !step_req) | (step_req & ~step_ack);
            if (state == EXEC && op == OP_CLR_ERR) begin
                frame_err <= 1'b0;
                err_cnt   <= '0;
            end else if (err) begin
                frame_err <= 1'b1;
                err_cnt   <= err_cnt + 8'(err_cnt != 8'hFF);
            end
        end
    end
endmodule

// File: tb/tb_dda_spi_ctrl.sv
// tb_dda_spi_ctrl: frame-level reference model vs dda_spi_ctrl under directed and random SPI traffic
module tb_dda_spi_ctrl;
    logic clk = 0, rst_n = 0, sclk = 0, cs_n = 1, mosi = 0, step_ack = 0;
    logic [15:0] x = 0, y = 0;
    logic miso, miso_oe, load_ic, step_req, frame_err;
    logic [15:0] mu, icx, icy;
    logic [7:0] err_cnt;

    dda_spi_ctrl dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .x(x), .y(y), .mu(mu), .icx(icx), .icy(icy),
        .load_ic(load_ic), .step_req(step_req), .step_ack(step_ack),
        .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    logic [15:0] m_mu = 16'h0000, m_icx = 16'h3000, m_icy = 16'h3000;
    logic m_ferr = 0, m_step = 0, prev_load = 0;
    int m_cnt = 0, m_loads = 0, loads_seen = 0;
    bit check_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: effect of one whole frame on the visible state
    task automatic bump();
        m_ferr = 1;
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic model_frame(input logic [31:0] w, input int nbits);
        if (nbits < 32) begin
            bump();
            return;
        end
        case (w[31:24])
            8'h00: ;
            8'h01: m_mu = w[15:0];
            8'h02: m_icx = w[15:0];
            8'h03: m_icy = w[15:0];
            8'h04: m_loads++;
            8'h05: if (m_step) bump(); else m_step = 1;
            8'h06: begin m_ferr = 0; m_cnt = 0; end
            default: bump();
        endcase
        if (nbits > 32) bump();
    endtask

    task automatic model_reset();
        m_mu = 16'h0000; m_icx = 16'h3000; m_icy = 16'h3000;
        m_ferr = 0; m_cnt = 0; m_step = 0;
    endtask

    always @(negedge clk) begin
        if (load_ic) begin
            loads_seen++;
            chk("load_ic_width", 32'(prev_load), 0);
        end
        prev_load = load_ic;
        if (check_on) begin
            chk("mu", 32'(mu), 32'(m_mu));
            chk("icx", 32'(icx), 32'(m_icx));
            chk("icy", 32'(icy), 32'(m_icy));
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
            chk("step_req", 32'(step_req), 32'(m_step));
            chk("load_ic_idle", 32'(load_ic), 0);
            chk("miso_oe_idle", 32'(miso_oe), 0);
        end
    end

    task automatic reset_checks();
        chk("rst_mu", 32'(mu), 32'h0000);
        chk("rst_icx", 32'(icx), 32'h3000);
        chk("rst_icy", 32'(icy), 32'h3000);
        chk("rst_load_ic", 32'(load_ic), 0);
        chk("rst_step_req", 32'(step_req), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_miso", 32'(miso), 0);
        chk("rst_miso_oe", 32'(miso_oe), 0);
    endtask

    // SPI mode 0 master, sclk half period 4 clk
    task automatic send_frame(input logic [31:0] w, input int nbits, input int rst_at,
                              input bit tchk, output logic [31:0] rd);
        logic [31:0] sh = w;
        rd = 0;
        @(negedge clk);
        check_on = 0;
        cs_n = 0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = sh[31];
            sh = sh << 1;
            repeat (4) @(negedge clk);
            if (i == 0 && rst_at < 0) chk("miso_oe_active", 32'(miso_oe), 1);
            sclk = 1;
            if (i < 32) rd = {rd[30:0], miso};
            else chk("miso_tail", 32'(miso), 0);
            if (i == 4) begin x = 16'($urandom); y = 16'($urandom); end
            if (i == rst_at) begin
                rst_n = 0;
                #1;
                reset_checks();
                repeat (2) @(negedge clk);
                rst_n = 1;
            end
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (tchk && i == 31 && k == 2) chk("mu_before_exec", 32'(mu), 32'h0000);
                if (tchk && i == 31 && k == 3) chk("mu_after_exec", 32'(mu), 32'h4000);
            end
            sclk = 0;
        end
        repeat (4) @(negedge clk);
        cs_n = 1;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame(input logic [31:0] w, input int nbits, input int rst_at,
                         input bit tchk, output logic [31:0] rd);
        logic [31:0] snap = {x, y};
        int nb = nbits < 32 ? nbits : 32;
        send_frame(w, nbits, rst_at, tchk, rd);
        if (rst_at < 0) begin
            model_frame(w, nbits);
            chk("miso_word", rd, snap >> (32 - nb));
            chk("load_cnt", 32'(loads_seen), 32'(m_loads));
        end else begin
            model_reset();
        end
        check_on = 1;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        check_on = 0;
        step_ack = 1;
        @(negedge clk);
        step_ack = 0;
        m_step = 0;
        chk("step_drop", 32'(step_req), 0);
        check_on = 1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0] op;
        int r, nb;
        repeat (3) @(negedge clk);
        reset_checks();
        rst_n = 1;
        repeat (5) @(negedge clk);
        check_on = 1;

        frame(32'h0100_4000, 32, -1, 1, rd);
        chk("wr_mu", 32'(mu), 32'h4000);
        chk("wr_mu_icx", 32'(icx), 32'h3000);
        chk("wr_mu_icy", 32'(icy), 32'h3000);
        chk("wr_mu_ferr", 32'(frame_err), 0);

        x = 16'hA5A5; y = 16'h5A5A;
        frame(32'h0000_0000, 32, -1, 0, rd);
        chk("miso_snapshot", rd, 32'hA5A55A5A);

        frame(32'h0500_0000, 32, -1, 0, rd);
        repeat (10) @(negedge clk);
        chk("step_held", 32'(step_req), 1);
        frame(32'h0500_0000, 32, -1, 0, rd);
        chk("step_dup_err", 32'(err_cnt), 1);
        ack_pulse();
        ack_pulse();

        frame(32'h0600_0000, 32, -1, 0, rd);
        frame(32'h0200_1234, 20, -1, 0, rd);
        chk("short_icx", 32'(icx), 32'h3000);
        chk("short_ferr", 32'(frame_err), 1);
        chk("short_cnt", 32'(err_cnt), 1);
        frame(32'h0200_1234, 34, -1, 0, rd);
        chk("long_icx", 32'(icx), 32'h1234);
        chk("long_cnt", 32'(err_cnt), 2);

        for (int i = 0; i < 260; i++) frame(32'h0100_0000, 1, -1, 0, rd);
        for (int i = 0; i < 40; i++) frame({8'($urandom_range(7, 255)), 24'($urandom)}, 32, -1, 0, rd);
        chk("sat_cnt", 32'(err_cnt), 32'hFF);
        frame(32'h0600_0000, 32, -1, 0, rd);
        chk("clr_cnt", 32'(err_cnt), 0);
        chk("clr_ferr", 32'(frame_err), 0);

        frame(32'h0100_1111, 32, 16, 0, rd);
        chk("rst_frame_mu", 32'(mu), 32'h0000);
        frame(32'h0300_7000, 32, -1, 0, rd);
        chk("post_rst_icy", 32'(icy), 32'h7000);

        for (int i = 0; i < 50; i++) begin
            r = $urandom_range(0, 9);
            op = r <= 6 ? 8'(r) : 8'($urandom_range(7, 255));
            r = $urandom_range(0, 9);
            nb = r < 8 ? 32 : r == 8 ? int'($urandom_range(33, 35)) : int'($urandom_range(1, 31));
            x = 16'($urandom); y = 16'($urandom);
            frame({op, 8'($urandom), 16'($urandom)}, nb, -1, 0, rd);
            if ($urandom_range(0, 2) == 0) ack_pulse();
        end
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
